isa_br_cond: RTL
================

Name: isa_br_cond

Overview:
- Parametrised successor to the single-mode register branch executor.
- Supports four branch modes: absolute, IP-relative, branch-if-zero and branch-if-nonzero. Conditional modes read a second register.
- Sits beside the other ISA executors: the decoder raises `enabled` and holds it until `finished`; the register file is shared through a `reg_id`/`reg_re`/`reg_out` read port; the fetch unit consumes `ip_set`/`ip_val`.

Parameters:
- DATA_W, 64, width of registers, IP and branch target.
- REG_ID_W, 4, register index width.
- INSN_BYTES, 8, instruction size added to IP to form the return address (link feature only).
- LINK_REG, 15, register index written with the return address (link feature only).

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  asynchronous reset, active-high.
- enabled  in  1  level request from decoder; held high until finished is seen.
- mode  in  2  0=ABS, 1=REL, 2=BZ, 3=BNZ; stable while enabled.
- r0  in  REG_ID_W  target/offset register index.
- r1  in  REG_ID_W  condition register index (BZ/BNZ only).
- ip_cur  in  DATA_W  IP of the current instruction.
- reg_out  in  DATA_W  register file read data.
- reg_id  out  REG_ID_W  register file read/write index.
- reg_re  out  1  read strobe.
- reg_we  out  1  write strobe (link feature only; 0 otherwise).
- reg_wdata  out  DATA_W  write data (link feature only; 0 otherwise).
- ip_set  out  1  one-cycle IP load pulse.
- ip_val  out  DATA_W  new IP, valid while ip_set is high.
- taken  out  1  branch decision, valid while finished is high.
- finished  out  1  done; held high until enabled falls.

Behaviour:
- Reset (async, any time): state=IDLE. Every output is 0; internal target and condition latches are 0.
- Read port timing:
  - reg_out is valid in the same cycle reg_re is high.
  - The block samples reg_out at the rising edge that ends that cycle.
  - reg_id = r0 in RD_TGT, r1 in RD_COND, LINK_REG in LINK; otherwise r0.
- States: IDLE, RD_TGT, RD_COND, LINK, SET, DONE. Outputs are registered.
- IDLE, enabled=1 → RD_TGT. Registered output: reg_re=1.
- RD_TGT: latch tgt=reg_out.
  - Mode BZ/BNZ → RD_COND, with reg_re kept at 1.
  - Mode ABS/REL → taken=1; go to LINK if the feature is compiled in, else SET.
- RD_COND: taken = (reg_out==0) for BZ, (reg_out!=0) for BNZ.
  - Taken → LINK (if compiled in) or SET.
  - Not taken → DONE with finished=1, taken=0, and ip_set never asserted.
- SET: ip_set=1 for exactly one cycle and finished=1.
  - ip_val = tgt for ABS/BZ/BNZ.
  - ip_val = ip_cur + tgt for REL: two's complement, truncated to DATA_W, wraps silently.
- DONE: ip_set=0; finished and taken held until enabled=0.
- Latency, with enabled sampled high at edge k:
  - ABS/REL: ip_set and finished high from cycle k+2.
  - BZ/BNZ: high from cycle k+3.
  - Link feature adds 1 cycle to taken branches.
- enabled=0 in any state: next edge → IDLE and all outputs clear. An aborted op must never produce ip_set after the abort edge.
- enabled rising again immediately after DONE→IDLE starts a fresh op; no stale latches are used.
- reg_re and reg_we are never high in the same cycle.

Optional Feature:
- ISA_BR_LINK_EN defined:
  - LINK state is inserted for taken branches: reg_we=1 for one cycle, reg_id=LINK_REG, reg_wdata = ip_cur + INSN_BYTES (mod 2^DATA_W).
  - SET follows. Not-taken branches never write.
  - If r0==LINK_REG, the target was already latched before the write, so the old value is used.
- ISA_BR_LINK_EN undefined: LINK state absent, and reg_we/reg_wdata are constant 0.

Decomposition:
- Shared package `isa_pkg`: the mode encodings (BR_ABS/BR_REL/BR_BZ/BR_BNZ) and the state enum.
- One sub-module, `br_cond_eval`: combinational decision of taken from mode and condition value, plus the target-address adder.

Test Plan:
- ABS, reg[3]=0x1000, r0=3, enabled held → ip_set one cycle at k+2 with ip_val=0x1000; finished stays high until enabled drops, then 0 next cycle.
- REL, ip_cur=0x200, reg[2]=0xFFFF_FFFF_FFFF_FFF0 (−16) → ip_val=0x1F0; and ip_cur=0xFFFF_FFFF_FFFF_FFF8 with offset 0x10 → ip_val=0x8 (wrap).
- BZ, r1=5 with reg[5]=0 → ip_set at k+3, taken=1. Then reg[5]=7 → no ip_set ever, finished at k+3, taken=0. BNZ checked with the mirror values.
- rst pulsed mid-RD_COND, and separately enabled dropped in RD_TGT → all outputs 0 immediately or next edge, no later ip_set; the next op completes normally.
- With ISA_BR_LINK_EN, ABS, ip_cur=0x400 → reg_we pulse with reg_id=15 and reg_wdata=0x408, then ip_set. With r0=15, ip_val equals the pre-write reg[15].

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA executor package: branch mode encodings, the branch executor
// state enum and a small mode helper.
// Optional macro: ISA_BR_LINK_EN adds the LINK state to the state enum.
package isa_pkg;

  typedef enum logic [1:0] {
    BR_ABS = 2'd0,
    BR_REL = 2'd1,
    BR_BZ  = 2'd2,
    BR_BNZ = 2'd3
  } br_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_TGT,
    ST_RD_COND,
`ifdef ISA_BR_LINK_EN
    ST_LINK,
`endif
    ST_SET,
    ST_DONE
  } br_state_e;

  // Conditional modes need a second register read.
  function automatic logic is_cond(input br_mode_e m);
    return (m == BR_BZ) || (m == BR_BNZ);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch evaluation.
// Ports:
//   mode     in   branch mode (isa_pkg::br_mode_e encoding)
//   cond_val in   condition register value (BZ/BNZ only)
//   ip_cur   in   IP of the current instruction
//   tgt      in   target / offset register value
//   taken    out  branch decision (always 1 for ABS/REL)
//   target   out  new IP: ip_cur+tgt for REL (wraps), tgt otherwise
module br_cond_eval
  import isa_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] cond_val,
  input  logic [DATA_W-1:0] ip_cur,
  input  logic [DATA_W-1:0] tgt,
  output logic              taken,
  output logic [DATA_W-1:0] target
);

  br_mode_e m;
  assign m = br_mode_e'(mode);

  always_comb begin
    taken = 1'b1;
    unique case (m)
      BR_BZ:   taken = (cond_val == '0);
      BR_BNZ:  taken = (cond_val != '0);
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    target = tgt;
    if (m == BR_REL) target = ip_cur + tgt;
  end

endmodule

// File: rtl/isa_br_cond.sv
// Four-mode register branch executor (ABS, REL, BZ, BNZ).
// Optional macro: ISA_BR_LINK_EN inserts a LINK state that writes
// ip_cur+INSN_BYTES to LINK_REG before the IP load on taken branches.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enabled         level request from decoder, held until finished
//   mode, r0, r1    branch mode, target register, condition register
//   ip_cur          IP of current instruction
//   reg_out         register file read data (valid while reg_re is high)
//   reg_id, reg_re  register file index and read strobe
//   reg_we, reg_wdata  link write port (constant 0 without the link feature)
//   ip_set, ip_val  one-cycle IP load to fetch
//   taken, finished branch decision and completion, held until enabled falls
module isa_br_cond
  import isa_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned REG_ID_W   = 4,
  parameter int unsigned INSN_BYTES = 8,
  parameter int unsigned LINK_REG   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enabled,
  input  logic [1:0]          mode,
  input  logic [REG_ID_W-1:0] r0,
  input  logic [REG_ID_W-1:0] r1,
  input  logic [DATA_W-1:0]   ip_cur,
  input  logic [DATA_W-1:0]   reg_out,
  output logic [REG_ID_W-1:0] reg_id,
  output logic                reg_re,
  output logic                reg_we,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic                ip_set,
  output logic [DATA_W-1:0]   ip_val,
  output logic                taken,
  output logic                finished
);

  br_state_e           state;
  logic [DATA_W-1:0]   tgt_q;
  logic [DATA_W-1:0]   tgt_src;
  logic [DATA_W-1:0]   target;
  logic                eval_taken;
  logic                go_taken;

  // In RD_TGT the target is still on the read bus; afterwards use the latch.
  assign tgt_src = (state == ST_RD_TGT) ? reg_out : tgt_q;

  br_cond_eval #(.DATA_W(DATA_W)) u_eval (
    .mode     (mode),
    .cond_val (reg_out),
    .ip_cur   (ip_cur),
    .tgt      (tgt_src),
    .taken    (eval_taken),
    .target   (target)
  );

  assign go_taken = ((state == ST_RD_TGT) && !is_cond(br_mode_e'(mode))) ||
                    ((state == ST_RD_COND) && eval_taken);

`ifdef ISA_BR_LINK_EN
  localparam logic [REG_ID_W-1:0] LINK_ID  = REG_ID_W'(LINK_REG);
  localparam logic [DATA_W-1:0]   INSN_INC = DATA_W'(INSN_BYTES);
`else
  logic unused_link_params;
  assign unused_link_params = ^{INSN_BYTES, LINK_REG};
  assign reg_we    = 1'b0;
  assign reg_wdata = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tgt_q    <= '0;
      reg_id   <= '0;
      reg_re   <= 1'b0;
      ip_set   <= 1'b0;
      ip_val   <= '0;
      taken    <= 1'b0;
      finished <= 1'b0;
`ifdef ISA_BR_LINK_EN
      reg_we    <= 1'b0;
      reg_wdata <= '0;
`endif
    end else begin
      reg_re <= 1'b0;
      ip_set <= 1'b0;
      ip_val <= '0;
      reg_id <= r0;
`ifdef ISA_BR_LINK_EN
      reg_we    <= 1'b0;
      reg_wdata <= '0;
`endif
      if (state == ST_RD_TGT && enabled) tgt_q <= reg_out;

      if (!enabled) begin
        state    <= ST_IDLE;
        reg_id   <= '0;
        taken    <= 1'b0;
        finished <= 1'b0;
      end else if (go_taken) begin
        taken <= 1'b1;
`ifdef ISA_BR_LINK_EN
        state     <= ST_LINK;
        reg_we    <= 1'b1;
        reg_id    <= LINK_ID;
        reg_wdata <= ip_cur + INSN_INC;
`else
        state    <= ST_SET;
        ip_set   <= 1'b1;
        ip_val   <= target;
        finished <= 1'b1;
`endif
      end else begin
        unique case (state)
          ST_IDLE: begin
            state  <= ST_RD_TGT;
            reg_re <= 1'b1;
            reg_id <= r0;
          end
          // Only conditional modes reach here from RD_TGT.
          ST_RD_TGT: begin
            state  <= ST_RD_COND;
            reg_re <= 1'b1;
            reg_id <= r1;
          end
          // Only not-taken branches reach here from RD_COND.
          ST_RD_COND: begin
            state    <= ST_DONE;
            taken    <= 1'b0;
            finished <= 1'b1;
          end
`ifdef ISA_BR_LINK_EN
          ST_LINK: begin
            state    <= ST_SET;
            ip_set   <= 1'b1;
            ip_val   <= target;
            finished <= 1'b1;
          end
`endif
          ST_SET:  state <= ST_DONE;
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
